// File: rtl/scan_mux_if.sv
// Bundle of channel inputs, handshake/control and registered outputs for scan_mux.
// The master modport belongs to the producer/consumer side, the slave modport to the mux.
interface scan_mux_if #(
    parameter int SELECT_LINES = 3,
    parameter int DATA_WIDTH   = 8
);
    localparam int CHANNELS = 2 ** SELECT_LINES;

    logic                         en;
    logic [CHANNELS*DATA_WIDTH-1:0] in;
    logic                         in_valid;
    logic [SELECT_LINES-1:0]      select;
    logic                         scan;
    logic                         scan_clear;
    logic [DATA_WIDTH-1:0]        out;
    logic                         out_valid;
    logic [SELECT_LINES-1:0]      out_select;
    logic                         out_last;

    modport master (
        output en, in, in_valid, select, scan, scan_clear,
        input  out, out_valid, out_select, out_last
    );

    modport slave (
        input  en, in, in_valid, select, scan, scan_clear,
        output out, out_valid, out_select, out_last
    );
endinterface

// File: rtl/scan_mux.sv
// Registered 2**SELECT_LINES-way mux with valid tag, clock enable and LATENCY-deep pipeline.
// Define MUX_SCAN_EN to build the auto-scan counter, scan/scan_clear handling and out_last.
module scan_mux #(
    parameter string BLOCK_NAME   = "scan_mux",
    parameter int    X            = 0,
    parameter int    Y            = 0,
    parameter int    DX           = 0,
    parameter int    DY           = 0,
    parameter string ARCHITECTURE = "BEHAVIORAL",
    parameter int    SELECT_LINES = 3,
    parameter int    DATA_WIDTH   = 8,
    parameter int    LATENCY      = 2
) (
    input  logic        clk,
    input  logic        rst,
    scan_mux_if.slave   bus
);
    localparam int unused_placement = X + Y + DX + DY + ((BLOCK_NAME == "") ? 0 : 1);

    if (ARCHITECTURE == "BEHAVIORAL") begin : g_behav
        logic [SELECT_LINES-1:0] sel_eff_s;
        logic [DATA_WIDTH-1:0]   chan_s;
        logic                    last_s;

        logic [DATA_WIDTH-1:0]   data_r [LATENCY];
        logic [SELECT_LINES-1:0] sel_r  [LATENCY];
        logic [LATENCY-1:0]      valid_r;
        logic [LATENCY-1:0]      last_r;

`ifdef MUX_SCAN_EN
        logic [SELECT_LINES-1:0] cnt_r;

        // Scan counter: advances per accepted scan word, restarts on scan_clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r <= '0;
            end else if (bus.en) begin
                if (bus.scan_clear) begin
                    cnt_r <= (bus.scan && bus.in_valid) ? SELECT_LINES'(1'b1) : '0;
                end else if (bus.scan && bus.in_valid) begin
                    cnt_r <= cnt_r + SELECT_LINES'(1'b1);
                end
            end
        end

        // scan_clear pulls the current scan word to channel 0 before the counter restarts
        assign sel_eff_s = bus.scan ? (bus.scan_clear ? '0 : cnt_r) : bus.select;
        assign last_s    = bus.in_valid & bus.scan & (&sel_eff_s);
`else
        logic unused_scan_s;
        assign unused_scan_s = bus.scan ^ bus.scan_clear;
        assign sel_eff_s     = bus.select;
        assign last_s        = 1'b0;
`endif

        assign chan_s = bus.in[DATA_WIDTH*int'(sel_eff_s) +: DATA_WIDTH];

        // Pipeline: stage 0 captures data and tags, later stages shift; en freezes everything.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < LATENCY; i++) begin
                    data_r[i] <= '0;
                    sel_r[i]  <= '0;
                end
                valid_r <= '0;
                last_r  <= '0;
            end else if (bus.en) begin
                data_r[0]  <= chan_s;
                sel_r[0]   <= sel_eff_s;
                valid_r[0] <= bus.in_valid;
                last_r[0]  <= last_s;
                for (int i = 1; i < LATENCY; i++) begin
                    data_r[i]  <= data_r[i-1];
                    sel_r[i]   <= sel_r[i-1];
                    valid_r[i] <= valid_r[i-1];
                    last_r[i]  <= last_r[i-1];
                end
            end
        end

        assign bus.out        = data_r[LATENCY-1];
        assign bus.out_select = sel_r[LATENCY-1];
        assign bus.out_valid  = valid_r[LATENCY-1];
        assign bus.out_last   = last_r[LATENCY-1];
    end else begin : g_none
        logic unused_inputs_s;
        assign unused_inputs_s = ^{clk, rst, bus.en, bus.in, bus.in_valid, bus.select,
                                   bus.scan, bus.scan_clear};
        assign bus.out        = '0;
        assign bus.out_select = '0;
        assign bus.out_valid  = 1'b0;
        assign bus.out_last   = 1'b0;
    end
endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: directed steps plus random traffic against a
// capture-history reference model (expected output = word captured LATENCY-1 enabled edges ago).
module tb_scan_mux;
    localparam int SL  = 3;
    localparam int DW  = 8;
    localparam int LAT = 2;
    localparam int N   = 2 ** SL;

    typedef struct {
        logic [DW-1:0] data;
        logic [SL-1:0] sel;
        logic          valid;
        logic          last;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    rec_t hist[$];
    int   cnt_m = 0;

    scan_mux_if #(.SELECT_LINES(SL), .DATA_WIDTH(DW)) bus ();

    scan_mux #(
        .SELECT_LINES(SL),
        .DATA_WIDTH(DW),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what the pipeline should capture on an enabled edge
    task automatic model_capture();
        rec_t r;
        logic [63:0] tmp;
        int   s;
        bit   is_scan;
        if (!bus.en) return;
        s = int'(bus.select);
        is_scan = 1'b0;
`ifdef MUX_SCAN_EN
        if (bus.scan) begin
            s = bus.scan_clear ? 0 : cnt_m;
            is_scan = 1'b1;
        end
        if (bus.scan_clear)
            cnt_m = (bus.scan && bus.in_valid) ? 1 : 0;
        else if (bus.scan && bus.in_valid)
            cnt_m = (cnt_m + 1) % N;
`endif
        tmp = bus.in >> (s * DW);
        r.data  = tmp[DW-1:0];
        r.sel   = SL'(s);
        r.valid = bus.in_valid;
        r.last  = bus.in_valid && is_scan && (s == N - 1);
        hist.push_back(r);
        if (hist.size() > LAT) void'(hist.pop_front());
    endtask

    task automatic compare_all();
        rec_t e;
        if (hist.size() >= LAT) begin
            e = hist[hist.size() - LAT];
        end else begin
            e.data = '0; e.sel = '0; e.valid = 1'b0; e.last = 1'b0;
        end
        check("out",        32'(bus.out),        32'(e.data));
        check("out_valid",  32'(bus.out_valid),  32'(e.valid));
        check("out_select", 32'(bus.out_select), 32'(e.sel));
        check("out_last",   32'(bus.out_last),   32'(e.last));
    endtask

    task automatic step(input logic e, input logic v, input logic [SL-1:0] s,
                        input logic sc, input logic clr, input logic [63:0] d);
        bus.en = e; bus.in_valid = v; bus.select = s;
        bus.scan = sc; bus.scan_clear = clr; bus.in = d;
        @(posedge clk);
        model_capture();
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out"},   32'(bus.out),        32'h0);
        check({tag, "_valid"}, 32'(bus.out_valid),  32'h0);
        check({tag, "_sel"},   32'(bus.out_select), 32'h0);
        check({tag, "_last"},  32'(bus.out_last),   32'h0);
    endtask

    localparam logic [63:0] PAT = 64'h17161514_13121110;

    initial begin
        int lasts;
        bus.en = 1'b0; bus.in_valid = 1'b0; bus.select = '0;
        bus.scan = 1'b0; bus.scan_clear = 1'b0; bus.in = '0;
        #12;
        check_zero("reset");
        rst = 1'b0;

        // Static select: channel 5 after two cycles
        step(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, PAT);
        step(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, PAT);
        check("static_out", 32'(bus.out), 32'h15);
        check("static_sel", 32'(bus.out_select), 32'd5);
        check("static_last", 32'(bus.out_last), 32'd0);
        step(1'b1, 1'b0, 3'd2, 1'b0, 1'b0, PAT);
        step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, PAT);
        step(1'b1, 1'b1, 3'd7, 1'b0, 1'b0, PAT);

`ifdef MUX_SCAN_EN
        // Scan sweep of 10 words, out_last exactly once
        lasts = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, (i < 10), 3'd0, 1'b1, 1'b0, PAT);
            if (bus.out_last === 1'b1) lasts++;
        end
        check("sweep_last_count", 32'(lasts), 32'd1);
        // Gap in in_valid, then stall
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, PAT);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, PAT);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, PAT);
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, PAT);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, PAT);
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, PAT);
        // Clear with and without in_valid
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b1, PAT);
        check("clear_sel0_pending", 32'(hist[hist.size()-1].sel), 32'd0);
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, PAT);
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, PAT);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, PAT);
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, PAT);
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, PAT);
        check("clear_novalid_sel", 32'(bus.out_select), 32'd0);
`else
        // Scan ignored: select wins, out_last never asserts
        lasts = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 3'd3, 1'b1, (i == 2), PAT);
            if (bus.out_last === 1'b1) lasts++;
        end
        check("noscan_sel", 32'(bus.out_select), 32'd3);
        check("noscan_out", 32'(bus.out), 32'h13);
        check("noscan_last_count", 32'(lasts), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd6, 1'b1, 1'b0, PAT);
        check("stall_hold_sel", 32'(bus.out_select), 32'd3);
        step(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, PAT);
        step(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, PAT);
        check("resume_out", 32'(bus.out), 32'h16);
`endif

        // Async reset mid-stream with two valid words in flight
        step(1'b1, 1'b1, 3'd4, 1'b1, 1'b0, PAT);
        step(1'b1, 1'b1, 3'd6, 1'b1, 1'b0, PAT);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        hist.delete();
        cnt_m = 0;
        @(posedge clk);
        #1 check_zero("rst_held");
        rst = 1'b0;
        step(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, PAT);
        step(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, PAT);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                 SL'($urandom_range(0, N - 1)), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0), {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
